// File: rtl/riscv_data_apb_bridge_pkg.sv
// Shared types, state encodings and byte-lane helpers for the RISC-V data-port to APB bridge.
package riscv_data_apb_pkg;

  // Bridge FSM state encodings
  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_SETUP      = 3'd1;
  localparam logic [2:0] ST_ACCESS     = 3'd2;
  localparam logic [2:0] ST_RMW_SETUP  = 3'd3;
  localparam logic [2:0] ST_RMW_ACCESS = 3'd4;

  // Core data-memory request
  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic        read_enable;
    logic        write_enable;
    logic [31:0] write_data;
  } data_access_req_t;

  // Core data-memory response; wait_ is the core's stall line
  typedef struct packed {
    logic        wait_;
    logic [31:0] read_data;
  } data_access_resp_t;

  // APB master request
  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
  } apb_request_t;

  // APB target response
  typedef struct packed {
    logic [31:0] prdata;
    logic        pready;
    logic        perr;
  } apb_response_t;

  // Expand a 4-bit byte enable into a 32-bit lane mask
  function automatic logic [31:0] expand_byte_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

  // Merge new lanes into an old word under a lane mask
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [31:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/riscv_data_apb_bridge_if.sv
// Bus bundle between the core data port, the bridge and the APB target fabric.
interface riscv_data_apb_bridge_if;
  import riscv_data_apb_pkg::*;

  data_access_req_t  data_access_req;
  data_access_resp_t data_access_resp;
  apb_request_t      apb_request;
  apb_response_t     apb_response;

  // Bridge view: APB master toward the fabric, responder toward the core
  modport master (
    input  data_access_req,
    input  apb_response,
    output data_access_resp,
    output apb_request
  );

  // Environment view: core plus APB target
  modport slave (
    output data_access_req,
    output apb_response,
    input  data_access_resp,
    input  apb_request
  );

endinterface

// File: rtl/riscv_data_apb_bridge.sv
// RISC-V data-port to APB master bridge with sub-word read-modify-write,
// ACCESS-phase timeout and sticky error-address capture.
module riscv_data_apb_bridge
  import riscv_data_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  riscv_data_apb_bridge_if.master bus,
  output logic                    access_error,
  output logic [31:0]             error_address
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic        write_q, write_d;
  logic        psel_q, psel_d;
  logic        penable_q, penable_d;
  logic        pwrite_q, pwrite_d;
  logic [31:0] paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        access_error_q, access_error_d;
  logic [31:0] error_address_q, error_address_d;

  logic        done;
  logic        flag_error;
  logic        accept;
  logic        timed_out;
  logic        resp_wait;
  logic [31:0] resp_rdata;

  data_access_req_t req;
  apb_response_t    rsp;

  assign req = bus.data_access_req;
  assign rsp = bus.apb_response;

  // Next-state, capture, merge and timeout decisions
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    be_d            = be_q;
    write_d         = write_q;
    pwrite_d        = pwrite_q;
    paddr_d         = paddr_q;
    pwdata_d        = pwdata_q;
    cnt_d           = cnt_q;
    done            = 1'b0;
    flag_error      = 1'b0;
    resp_rdata      = 32'h0;
    accept          = 1'b0;
    timed_out       = !rsp.pready && (cnt_q == TIMEOUT_LAST);

    case (state_q)
      ST_IDLE: begin
        if (req.write_enable) begin
          if (req.byte_enable != 4'h0) begin
            accept   = 1'b1;
            addr_d   = req.address;
            be_d     = req.byte_enable;
            write_d  = 1'b1;
            paddr_d  = {16'h0, req.address[17:2]};
            pwdata_d = req.write_data;
            if (req.byte_enable == 4'hF) begin
              pwrite_d = 1'b1;
              state_d  = ST_SETUP;
            end else begin
              pwrite_d = 1'b0;
              state_d  = ST_RMW_SETUP;
            end
          end
        end else if (req.read_enable) begin
          accept   = 1'b1;
          addr_d   = req.address;
          be_d     = req.byte_enable;
          write_d  = 1'b0;
          pwrite_d = 1'b0;
          paddr_d  = {16'h0, req.address[17:2]};
          state_d  = ST_SETUP;
        end
      end

      ST_RMW_SETUP: begin
        cnt_d   = 16'h0;
        state_d = ST_RMW_ACCESS;
      end

      ST_RMW_ACCESS: begin
        if (rsp.pready) begin
          if (rsp.perr) begin
            done       = 1'b1;
            flag_error = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            pwdata_d = merge_bytes(rsp.prdata, pwdata_q, expand_byte_mask(be_q));
            pwrite_d = 1'b1;
            state_d  = ST_SETUP;
          end
        end else if (timed_out) begin
          done       = 1'b1;
          flag_error = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_SETUP: begin
        cnt_d   = 16'h0;
        state_d = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (rsp.pready) begin
          done       = 1'b1;
          flag_error = rsp.perr;
          resp_rdata = write_q ? 32'h0 : rsp.prdata;
          state_d    = ST_IDLE;
        end else if (timed_out) begin
          done       = 1'b1;
          flag_error = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    resp_wait       = (state_q == ST_IDLE) ? accept : !done;
    psel_d          = (state_d != ST_IDLE);
    penable_d       = (state_d == ST_ACCESS) || (state_d == ST_RMW_ACCESS);
    access_error_d  = flag_error;
    error_address_d = flag_error ? addr_q : error_address_q;
  end

  // State and capture registers; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= 32'h0;
      be_q            <= 4'h0;
      write_q         <= 1'b0;
      psel_q          <= 1'b0;
      penable_q       <= 1'b0;
      pwrite_q        <= 1'b0;
      paddr_q         <= 32'h0;
      pwdata_q        <= 32'h0;
      cnt_q           <= 16'h0;
      access_error_q  <= 1'b0;
      error_address_q <= 32'h0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      be_q            <= be_d;
      write_q         <= write_d;
      psel_q          <= psel_d;
      penable_q       <= penable_d;
      pwrite_q        <= pwrite_d;
      paddr_q         <= paddr_d;
      pwdata_q        <= pwdata_d;
      cnt_q           <= cnt_d;
      access_error_q  <= access_error_d;
      error_address_q <= error_address_d;
    end
  end

  assign bus.apb_request = '{psel:    psel_q,
                             penable: penable_q,
                             pwrite:  pwrite_q,
                             paddr:   paddr_q,
                             pwdata:  pwdata_q};

  assign bus.data_access_resp = '{wait_: resp_wait, read_data: resp_rdata};

  assign access_error  = access_error_q;
  assign error_address = error_address_q;

endmodule
